// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side controller of the async FIFO.
// Synchronises the Gray write pointer into rd_clk through two flops, and keeps
// the binary and Gray read pointers. It raises rd_empty conservatively and pulses
// rd_err when a read is requested while the FIFO is empty.
// Optional feature: define FIFO_RD_LEVEL_EN to add rd_level and rd_almost_empty.
module fifo_rd_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int AE_THRESH  = 2
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic                  rd_empty,
`ifdef FIFO_RD_LEVEL_EN
  output logic                  rd_err,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  rd_almost_empty
`else
  output logic                  rd_err
`endif
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] wq1;
  logic [PW-1:0] wq2;
  logic [PW-1:0] rd_bin;
  logic [PW-1:0] rd_bin_nxt;
  logic [PW-1:0] rd_gray_nxt;
  logic          rd_inc;

  // A read only advances the pointer when there is something to read
  assign rd_inc      = rd_en & ~rd_empty;
  assign rd_bin_nxt  = rd_bin + {{ADDR_WIDTH{1'b0}}, rd_inc};
  assign rd_gray_nxt = rd_bin_nxt ^ (rd_bin_nxt >> 1);
  assign rd_addr     = rd_bin[ADDR_WIDTH-1:0];

  // Two-flop synchroniser; wq2 is the only view of the write pointer used here
  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      wq1 <= '0;
      wq2 <= '0;
    end else begin
      wq1 <= wr_ptr_gray;
      wq2 <= wq1;
    end
  end

  // Read pointers, the empty flag and the underflow pulse all move together
  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      rd_bin      <= '0;
      rd_ptr_gray <= '0;
      rd_empty    <= 1'b1;
      rd_err      <= 1'b0;
    end else begin
      rd_bin      <= rd_bin_nxt;
      rd_ptr_gray <= rd_gray_nxt;
      rd_empty    <= (rd_gray_nxt == wq2);
      rd_err      <= rd_en & rd_empty;
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  localparam logic [PW-1:0] AE_LIMIT = PW'(AE_THRESH);

  logic [PW-1:0] wq2_bin;
  logic [PW-1:0] rd_level_nxt;

  // The level needs the synchronised write pointer back in binary form
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign wq2_bin      = gray2bin(wq2);
  assign rd_level_nxt = wq2_bin - rd_bin_nxt;

  // The level flags update on the same edge as rd_empty, so all three stay coherent
  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      rd_level        <= '0;
      rd_almost_empty <= 1'b1;
    end else begin
      rd_level        <= rd_level_nxt;
      rd_almost_empty <= (rd_level_nxt <= AE_LIMIT);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: scoreboard bench for fifo_rd_ctrl at ADDR_WIDTH=2, AE_THRESH=1.
// Each cycle of stimulus pushes the expected post-edge outputs into a queue.
// A monitor process pops one entry after each rising edge and compares it.
module tb_fifo_rd_ctrl;

  localparam int AW    = 2;
  localparam int AE    = 1;
  localparam int DEPTH = 1 << AW;
  localparam int PMOD  = 2 * DEPTH;

  logic          rd_clk;
  logic          rd_rst_n;
  logic          rd_en;
  logic [AW:0]   wr_ptr_gray;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   rd_ptr_gray;
  logic          rd_empty;
  logic          rd_err;
`ifdef FIFO_RD_LEVEL_EN
  logic [AW:0]   rd_level;
  logic          rd_almost_empty;
`endif

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [AW:0]   gray;
    logic          empty;
    logic          err;
    logic [AW:0]   level;
    logic          ae;
  } exp_t;

  exp_t expQ[$];
  int   testsRun  = 0;
  int   failCount = 0;

  // Reference model: a read count, the write count as the read side sees it
  // (two edges late), and the flags derived from the visible occupancy
  int   mRead    = 0;
  int   mSeen1   = 0;
  int   mSeen2   = 0;
  logic mEmpty   = 1'b1;
  int   wrCount  = 0;

  fifo_rd_ctrl #(.ADDR_WIDTH(AW), .AE_THRESH(AE)) dut (
    .rd_clk          (rd_clk),
    .rd_rst_n        (rd_rst_n),
    .rd_en           (rd_en),
    .wr_ptr_gray     (wr_ptr_gray),
    .rd_addr         (rd_addr),
    .rd_ptr_gray     (rd_ptr_gray),
    .rd_empty        (rd_empty),
`ifdef FIFO_RD_LEVEL_EN
    .rd_err          (rd_err),
    .rd_level        (rd_level),
    .rd_almost_empty (rd_almost_empty)
`else
    .rd_err          (rd_err)
`endif
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  function automatic logic [AW:0] toGray(input int b);
    logic [AW:0] v;
    v = (AW+1)'(b % PMOD);
    return v ^ (v >> 1);
  endfunction

  // Drive one cycle of inputs and predict the outputs after the coming edge
  task automatic applyStimulus(input logic rstN, input logic en, input int w);
    exp_t e;
    int   occ;
    logic doRead;
    @(negedge rd_clk);
    rd_rst_n    = rstN;
    rd_en       = en;
    wr_ptr_gray = toGray(w);
    e.err = 1'b0;
    if (!rstN) begin
      mRead  = 0;
      mSeen1 = 0;
      mSeen2 = 0;
      mEmpty = 1'b1;
      occ    = 0;
    end else begin
      doRead = en && !mEmpty;
      e.err  = en && mEmpty;
      if (doRead) mRead = (mRead + 1) % PMOD;
      occ    = ((mSeen2 - mRead) % PMOD + PMOD) % PMOD;
      mEmpty = (occ == 0);
      mSeen2 = mSeen1;
      mSeen1 = w % PMOD;
    end
    e.addr  = AW'(mRead % DEPTH);
    e.gray  = toGray(mRead);
    e.empty = mEmpty;
    e.level = (AW+1)'(occ);
    e.ae    = (occ <= AE);
    expQ.push_back(e);
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    testsRun++;
    if (act != exp) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("rd_addr", int'(rd_addr), int'(e.addr));
    cmp("rd_ptr_gray", int'(rd_ptr_gray), int'(e.gray));
    cmp("rd_empty", int'(rd_empty), int'(e.empty));
    cmp("rd_err", int'(rd_err), int'(e.err));
`ifdef FIFO_RD_LEVEL_EN
    cmp("rd_level", int'(rd_level), int'(e.level));
    cmp("rd_almost_empty", int'(rd_almost_empty), int'(e.ae));
`endif
  endtask

  // Monitor: compare every edge's outputs against the oldest prediction
  always @(posedge rd_clk) begin
    exp_t e;
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput(e);
    end
  end

  initial begin
    rd_rst_n    = 1'b0;
    rd_en       = 1'b0;
    wr_ptr_gray = '0;

    // Reset held for two edges
    repeat (2) applyStimulus(1'b0, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, 0);

    // Sync latency, then a single read that empties the FIFO
    repeat (3) applyStimulus(1'b1, 1'b0, 1);
    applyStimulus(1'b1, 1'b1, 1);
    repeat (2) applyStimulus(1'b1, 1'b0, 1);

    // Full-depth wrap: four writes then four reads
    applyStimulus(1'b0, 1'b0, 0);
    for (int i = 1; i <= DEPTH; i++) applyStimulus(1'b1, 1'b0, i);
    repeat (3) applyStimulus(1'b1, 1'b0, DEPTH);
    repeat (DEPTH) applyStimulus(1'b1, 1'b1, DEPTH);
    applyStimulus(1'b1, 1'b0, DEPTH);

    // Underflow while empty
    repeat (2) applyStimulus(1'b1, 1'b1, DEPTH);
    repeat (2) applyStimulus(1'b1, 1'b0, DEPTH);

    // Reset in the middle of operation
    applyStimulus(1'b0, 1'b0, 0);
    repeat (3) applyStimulus(1'b1, 1'b0, 3);
    repeat (2) applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b0, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, 0);

    // Level scenario: three entries, settle, then two reads
    applyStimulus(1'b0, 1'b0, 0);
    repeat (4) applyStimulus(1'b1, 1'b0, 3);
    repeat (2) applyStimulus(1'b1, 1'b1, 3);
    repeat (2) applyStimulus(1'b1, 1'b0, 3);

    // Randomised traffic with a writer that never overfills the FIFO
    applyStimulus(1'b0, 1'b0, 0);
    wrCount = 0;
    for (int i = 0; i < 400; i++) begin
      logic rstN;
      rstN = ($urandom_range(0, 59) != 0);
      if (!rstN) begin
        wrCount = 0;
      end else if ($urandom_range(0, 1) == 1 &&
                   (((wrCount - mRead) % PMOD + PMOD) % PMOD) < DEPTH) begin
        wrCount = (wrCount + 1) % PMOD;
      end
      applyStimulus(rstN, 1'($urandom_range(0, 1)), rstN ? wrCount : 0);
    end

    repeat (3) @(posedge rd_clk);
    #2;
    testsRun++;
    if (expQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
